// File: rtl/fifo_rx_credit.sv
// -----------------------------------------------------------------------------
// fifo_rx_credit
//
// Receive-side character buffer between the SpaceWire receiver and the host.
// Stores N-Chars from the receiver in a 2**AWIDTH deep FIFO and returns them
// to the host on request. It also owns the link flow-control credit: it tracks
// how many characters the far end may still send and requests an FCT from the
// transmitter whenever eight more slots can be promised.
//
// Build option:
//   SPW_RX_CREDIT_CHECK_EN  defined   -> credit_err pulses when a character
//                                        arrives with zero credit outstanding
//                           undefined -> credit_err is tied low
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   flush        synchronous clear (link left Run)
//   wr_en        receiver strobe, data_in holds a character
//   data_in      received character (8 data bits + control flag)
//   rd_en        host read request
//   fct_sent     transmitter pulse: requested FCT has gone out
//   data_out     registered read data
//   data_valid   one-cycle pulse, data_out valid
//   f_full       counter == depth
//   f_empty      counter == 0
//   counter      characters stored (0..depth)
//   fct_request  level request for one FCT
//   credit_err   pulse: character received with zero credit
//   overflow_err pulse: character received while full (dropped)
// -----------------------------------------------------------------------------
module fifo_rx_credit #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    input  logic              fct_sent,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              f_full,
    output logic              f_empty,
    output logic [AWIDTH:0]   counter,
    output logic              fct_request,
    output logic              credit_err,
    output logic              overflow_err
);

    localparam int DEPTH = 2**AWIDTH;

    // Count-width constants
    localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   SLOT_8_W  = (AWIDTH+1)'(8);
    localparam logic [AWIDTH:0]   ZERO_W    = (AWIDTH+1)'(0);
    localparam logic [AWIDTH:0]   ONE_W     = (AWIDTH+1)'(1);
    // A request is only allowed while a further grant of 8 keeps credit
    // within depth-8 (56 for the default depth).
    localparam logic [AWIDTH-1:0] CREDIT_REQ_MAX = AWIDTH'(DEPTH - 16);
    localparam logic [AWIDTH-1:0] ZERO_A    = AWIDTH'(0);
    localparam logic [AWIDTH-1:0] ONE_A     = AWIDTH'(1);

    typedef enum logic [1:0] {
        CR_IDLE   = 2'd0,
        CR_REQ    = 2'd1,
        CR_SETTLE = 2'd2
    } cr_state_e;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AWIDTH:0]   count_q,    count_d;
    logic [AWIDTH-1:0] credit_q,   credit_d;
    cr_state_e         state_q,    state_d;
    logic [DWIDTH-1:0] data_out_q, data_out_d;
    logic              data_valid_q,   data_valid_d;
    logic              f_full_q,       f_full_d;
    logic              f_empty_q,      f_empty_d;
    logic              fct_request_q,  fct_request_d;
    logic              credit_err_q,   credit_err_d;
    logic              overflow_err_q, overflow_err_d;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              grant_s;
    logic              mem_we_s;
    logic [AWIDTH:0]   free_s;
    logic [AWIDTH:0]   credit_sum_s;

    // Next-state logic for pointers, occupancy, credit, FSM and outputs
    always_comb begin
        // Flags are the registered view of the previous edge, so a read at
        // full frees no slot for a write in the same cycle.
        wr_acc_s = wr_en && !f_full_q;
        rd_acc_s = rd_en && !f_empty_q;
        grant_s  = (state_q == CR_REQ) && fct_sent;
        mem_we_s = wr_acc_s && !flush;

        // Credit never exceeds free space, so this cannot go negative.
        free_s = DEPTH_W - count_q - {1'b0, credit_q};

        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        credit_d       = credit_q;
        state_d        = state_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        credit_err_d   = 1'b0;
        overflow_err_d = 1'b0;
        credit_sum_s   = {1'b0, credit_q};

        if (flush) begin
            wr_ptr_d = ZERO_A;
            rd_ptr_d = ZERO_A;
            count_d  = ZERO_W;
            credit_d = ZERO_A;
            state_d  = CR_IDLE;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + ONE_A;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (rd_acc_s) begin
                rd_ptr_d     = rd_ptr_q + ONE_A;
                data_out_d   = mem_q[rd_ptr_q];
                data_valid_d = 1'b1;
            end else begin
                rd_ptr_d     = rd_ptr_q;
                data_out_d   = data_out_q;
                data_valid_d = 1'b0;
            end

            if (wr_acc_s && !rd_acc_s) begin
                count_d = count_q + ONE_W;
            end else if (rd_acc_s && !wr_acc_s) begin
                count_d = count_q - ONE_W;
            end else begin
                count_d = count_q;
            end

            // Grant first, then consume: a grant and a write together net +7,
            // and a write at zero credit saturates instead of wrapping.
            if (grant_s) begin
                credit_sum_s = {1'b0, credit_q} + SLOT_8_W;
            end else begin
                credit_sum_s = {1'b0, credit_q};
            end
            if (wr_acc_s && (credit_sum_s != ZERO_W)) begin
                credit_sum_s = credit_sum_s - ONE_W;
            end else begin
                credit_sum_s = credit_sum_s;
            end
            credit_d = credit_sum_s[AWIDTH-1:0];

            overflow_err_d = wr_en && f_full_q;
`ifdef SPW_RX_CREDIT_CHECK_EN
            credit_err_d = wr_en && (credit_q == ZERO_A);
`else
            credit_err_d = 1'b0;
`endif

            case (state_q)
                CR_IDLE: begin
                    if ((free_s >= SLOT_8_W) && (credit_q <= CREDIT_REQ_MAX)) begin
                        state_d = CR_REQ;
                    end else begin
                        state_d = CR_IDLE;
                    end
                end
                CR_REQ: begin
                    if (fct_sent) begin
                        state_d = CR_SETTLE;
                    end else begin
                        state_d = CR_REQ;
                    end
                end
                // One idle cycle lets count/credit settle so the same free
                // space is never promised twice.
                CR_SETTLE: state_d = CR_IDLE;
                default:   state_d = CR_IDLE;
            endcase
        end

        // Flags and request are registered from next-state values so they
        // always line up with counter and the FSM state.
        f_full_d      = (count_d == DEPTH_W);
        f_empty_d     = (count_d == ZERO_W);
        fct_request_d = (state_d == CR_REQ);
    end

    // State, FSM and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= ZERO_A;
            rd_ptr_q       <= ZERO_A;
            count_q        <= ZERO_W;
            credit_q       <= ZERO_A;
            state_q        <= CR_IDLE;
            data_out_q     <= {DWIDTH{1'b0}};
            data_valid_q   <= 1'b0;
            f_full_q       <= 1'b0;
            f_empty_q      <= 1'b1;
            fct_request_q  <= 1'b0;
            credit_err_q   <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            credit_q       <= credit_d;
            state_q        <= state_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            f_full_q       <= f_full_d;
            f_empty_q      <= f_empty_d;
            fct_request_q  <= fct_request_d;
            credit_err_q   <= credit_err_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Character storage; contents survive reset and flush
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign f_full       = f_full_q;
    assign f_empty      = f_empty_q;
    assign counter      = count_q;
    assign fct_request  = fct_request_q;
    assign credit_err   = credit_err_q;
    assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_fifo_rx_credit.sv
// -----------------------------------------------------------------------------
// tb_fifo_rx_credit
//
// Directed bench for fifo_rx_credit. Reads issued by the stimulus push their
// expected character into exp_q; an independent monitor compares data_out
// against the queue head whenever data_valid is seen.
// -----------------------------------------------------------------------------
module tb_fifo_rx_credit;

`ifdef SPW_RX_CREDIT_CHECK_EN
    localparam int CRED_CHK = 1;
`else
    localparam int CRED_CHK = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic       wr_en;
    logic [8:0] data_in;
    logic       rd_en;
    logic       fct_sent;
    logic [8:0] data_out;
    logic       data_valid;
    logic       f_full;
    logic       f_empty;
    logic [6:0] counter;
    logic       fct_request;
    logic       credit_err;
    logic       overflow_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [8:0] model_q [$];
    logic [8:0] exp_q   [$];

    fifo_rx_credit #(.DWIDTH(9), .AWIDTH(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .fct_sent     (fct_sent),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .f_full       (f_full),
        .f_empty      (f_empty),
        .counter      (counter),
        .fct_request  (fct_request),
        .credit_err   (credit_err),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fct_request) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Answer an outstanding request two cycles later
    task automatic grant();
        tick();
        tick();
        fct_sent = 1'b1;
        tick();
        fct_sent = 1'b0;
        chk("fct_fall", fct_request, 0);
    endtask

    task automatic write_one(input logic [8:0] d);
        wr_en   = 1'b1;
        data_in = d;
        if (model_q.size() < 64) model_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(negedge clock);
            if (data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL rd_unexpected: got data_valid with 0x%03h, expected none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", data_out, e);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stim
        bit got;
        int nreq;

        reset    = 1'b0;
        flush    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        fct_sent = 1'b0;
        data_in  = 9'h000;
        tick();
        tick();

        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_f_full", f_full, 0);
        chk("rst_f_empty", f_empty, 1);
        chk("rst_counter", counter, 0);
        chk("rst_fct_request", fct_request, 0);
        chk("rst_credit_err", credit_err, 0);
        chk("rst_overflow_err", overflow_err, 0);
        reset = 1'b1;

        // Credit build-up from zero: 7 grants to reach 56
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            wait_req(got);
            if (!got) break;
            grant();
            nreq++;
        end
        chk("init_req_count", nreq, 7);
        chk("init_fct_request", fct_request, 0);
        chk("init_counter", counter, 0);
        chk("init_f_empty", f_empty, 1);

        // Consume all 56 credits
        for (int i = 0; i < 56; i++) begin
            wr_en   = 1'b1;
            data_in = 9'(i);
            model_q.push_back(9'(i));
            tick();
        end
        wr_en = 1'b0;
        chk("w56_counter", counter, 56);
        chk("w56_f_full", f_full, 0);
        chk("w56_fct_request", fct_request, 1);
        grant();

        for (int i = 56; i < 64; i++) begin
            wr_en   = 1'b1;
            data_in = 9'(i);
            model_q.push_back(9'(i));
            tick();
        end
        wr_en = 1'b0;
        chk("w64_counter", counter, 64);
        chk("w64_f_full", f_full, 1);
        chk("w64_f_empty", f_empty, 0);
        repeat (10) tick();
        chk("full_no_request", fct_request, 0);

        // Write while full: dropped
        wr_en   = 1'b1;
        data_in = 9'h1FF;
        tick();
        wr_en = 1'b0;
        chk("ovf_pulse", overflow_err, 1);
        chk("ovf_credit_err", credit_err, CRED_CHK);
        chk("ovf_counter", counter, 64);
        tick();
        chk("ovf_pulse_end", overflow_err, 0);

        // Read 60, leaving addresses 60..63
        for (int i = 0; i < 60; i++) begin
            rd_en = 1'b1;
            exp_q.push_back(model_q.pop_front());
            tick();
        end
        rd_en = 1'b0;
        chk("r60_counter", counter, 4);

        // Write at zero credit (lands at address 0)
        write_one(9'h100);
        chk("cred0_credit_err", credit_err, CRED_CHK);
        chk("cred0_counter", counter, 5);
        chk("cred0_overflow_err", overflow_err, 0);
        tick();
        chk("cred0_pulse_end", credit_err, 0);

        // Simultaneous read and write at counter 5
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            data_in = 9'h101 + 9'(i);
            exp_q.push_back(model_q.pop_front());
            model_q.push_back(9'h101 + 9'(i));
            tick();
            chk("rw_counter", counter, 5);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Drain across the 63->0 wrap
        while (model_q.size() > 0) begin
            rd_en = 1'b1;
            exp_q.push_back(model_q.pop_front());
            tick();
        end
        rd_en = 1'b0;
        chk("drain_counter", counter, 0);
        chk("drain_f_empty", f_empty, 1);

        // Read while empty
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_rd_valid", data_valid, 0);
        end
        rd_en = 1'b0;
        chk("empty_rd_counter", counter, 0);

        // Build counter 20, credit 16, pending request; then flush
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b1;
            data_in = 9'h0C0 + 9'(i);
            model_q.push_back(9'h0C0 + 9'(i));
            tick();
        end
        wr_en = 1'b0;
        chk("pre_flush_counter", counter, 20);
        chk("pre_flush_req", fct_request, 1);
        grant();
        wait_req(got);
        chk("pre_flush_req2", int'(got), 1);
        grant();
        wait_req(got);
        chk("pre_flush_req3", int'(got), 1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_q.delete();
        chk("flush_counter", counter, 0);
        chk("flush_f_empty", f_empty, 1);
        chk("flush_f_full", f_full, 0);
        chk("flush_fct_request", fct_request, 0);
        tick();
        chk("flush_rereq", fct_request, 1);

        // Post-flush traffic; credit was cleared to zero by the flush
        write_one(9'h0AA);
        chk("pf_counter", counter, 1);
        chk("pf_credit_err", credit_err, CRED_CHK);
        rd_en = 1'b1;
        exp_q.push_back(model_q.pop_front());
        tick();
        rd_en = 1'b0;
        chk("pf_counter_after_rd", counter, 0);

        repeat (3) tick();
        chk("sb_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
